// File: rtl/unified_mem_responder_if.sv
// Request/response bus between the control path and the unified memory responder.
interface unified_mem_responder_if;
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output req, write, addr, wdata, byte_en,
        input  rdata, ready, busy, addr_err
    );

    modport slave (
        input  req, write, addr, wdata, byte_en,
        output rdata, ready, busy, addr_err
    );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-port word-organised instruction/data memory with a wait-state request/ready handshake.
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned byte addresses via addr_err.
module unified_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    unified_mem_responder_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                write_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic                accept;
    logic                commit;
    logic                req_err;
    logic [31:0]         mem [Depth];

`ifdef MEM_ALIGN_CHECK_EN
    assign req_err = (bus.addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Upper address bits wrap; the byte offset only matters to the alignment check.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    // WAIT spans WAIT_CYCLES+1 cycles so Ready rises WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    state_d = StWait;
                    cnt_d   = 3'(WAIT_CYCLES);
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= bus.write;
                idx_q   <= bus.addr[ADDR_W+1:2];
                wdata_q <= bus.wdata;
                be_q    <= bus.byte_en;
                err_q   <= req_err;
            end
            if (commit && !write_q && !err_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Array is deliberately not reset; commit is impossible while reset holds state in StIdle.
    always_ff @(posedge clk_i) begin
        if (commit && write_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = (state_q == StResp);
    assign bus.busy     = (state_q != StIdle);
    assign bus.addr_err = (state_q == StResp) && err_q;
endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomised self-checking bench for unified_mem_responder with WAIT_CYCLES=2 and =0 instances.
module tb_unified_mem_responder;
    localparam int unsigned AW    = 10;
    localparam int unsigned Depth = 1024;
    localparam int          D2    = 0;  // instance with two wait states
    localparam int          D0    = 1;  // instance with zero wait states

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    unified_mem_responder_if bus2 ();
    unified_mem_responder_if bus0 ();

    unified_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    unified_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    // Reference model: word array per instance plus the last completed read value.
    logic [31:0] ref_mem [2][Depth];
    logic [31:0] ref_rd  [2];

    function automatic int widx(logic [31:0] a);
        return int'((a / 4) % Depth);
    endfunction

    function automatic logic ref_err(logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(int d);
        return (d == D2) ? 3 : 1;
    endfunction

    task automatic ref_apply(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] m;
        if (ref_err(a)) return;
        if (w) begin
            m = '0;
            for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
            ref_mem[d][widx(a)] = (ref_mem[d][widx(a)] & ~m) | (wd & m);
        end else begin
            ref_rd[d] = ref_mem[d][widx(a)];
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (d == D2) begin
            bus2.req = r; bus2.write = w; bus2.addr = a; bus2.wdata = wd; bus2.byte_en = be;
        end else begin
            bus0.req = r; bus0.write = w; bus0.addr = a; bus0.wdata = wd; bus0.byte_en = be;
        end
    endtask

    function automatic logic get_ready(int d);
        return (d == D2) ? bus2.ready : bus0.ready;
    endfunction
    function automatic logic get_busy(int d);
        return (d == D2) ? bus2.busy : bus0.busy;
    endfunction
    function automatic logic get_err(int d);
        return (d == D2) ? bus2.addr_err : bus0.addr_err;
    endfunction
    function automatic logic [31:0] get_rdata(int d);
        return (d == D2) ? bus2.rdata : bus0.rdata;
    endfunction

    // One request; reports latency in edges, data/error at Ready, and whether Busy behaved.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] rd,
                        output logic err, output logic busy_ok);
        @(negedge clk);
        drive(d, 1'b1, w, a, wd, be);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, '0, '0, '0);
        busy_ok = get_busy(d) && !get_ready(d);
        lat = -1;
        rd  = '0;
        err = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (!get_busy(d)) busy_ok = 1'b0;
            if (get_ready(d)) begin
                lat = k;
                rd  = get_rdata(d);
                err = get_err(d);
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            if (get_busy(d) || get_ready(d)) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(D2, 1'b0, 1'b0, '0, '0, '0);
        drive(D0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (get_ready(d) !== 1'b0) begin n_bad++;
                $display("FAIL reset_ready[%0d]: got %b want 0", d, get_ready(d)); end
            n_cmp++; if (get_busy(d) !== 1'b0) begin n_bad++;
                $display("FAIL reset_busy[%0d]: got %b want 0", d, get_busy(d)); end
            n_cmp++; if (get_err(d) !== 1'b0) begin n_bad++;
                $display("FAIL reset_err[%0d]: got %b want 0", d, get_err(d)); end
            n_cmp++; if (get_rdata(d) !== 32'd0) begin n_bad++;
                $display("FAIL reset_rdata[%0d]: got %h want 0", d, get_rdata(d)); end
        end
        @(negedge clk);
        rst_n     = 1'b1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic err, bok;
        ref_apply(D2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xact(D2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err, bok);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_lat: got %0d want 3", lat); end
        n_cmp++; if (rd !== ref_rd[D2]) begin n_bad++;
            $display("FAIL wr_rdata_held: got %h want %h", rd, ref_rd[D2]); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", bok); end
        ref_apply(D2, 1'b0, 32'h10, '0, '0);
        xact(D2, 1'b0, 32'h10, '0, '0, lat, rd, err, bok);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_lat: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL rd_data: got %h want deadbeef", rd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", err); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic err, bok;
        ref_apply(D2, 1'b1, 32'h20, 32'h11223344, 4'hF);
        xact(D2, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, err, bok);
        ref_apply(D2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        xact(D2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, err, bok);
        ref_apply(D2, 1'b1, 32'h20, 32'h99999999, 4'b0000);
        xact(D2, 1'b1, 32'h20, 32'h99999999, 4'b0000, lat, rd, err, bok);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL be0_lat: got %0d want 3", lat); end
        ref_apply(D2, 1'b0, 32'h20, '0, '0);
        xact(D2, 1'b0, 32'h20, '0, '0, lat, rd, err, bok);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++;
            $display("FAIL lanes_data: got %h want 11bb33dd", rd); end
        n_cmp++; if (rd !== ref_rd[D2]) begin n_bad++;
            $display("FAIL lanes_model: got %h want %h", rd, ref_rd[D2]); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic err, bok;
        ref_apply(D0, 1'b1, 32'h0, 32'h5A5AA5A5, 4'hF);
        xact(D0, 1'b1, 32'h0, 32'h5A5AA5A5, 4'hF, lat, rd, err, bok);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zw_wr_lat: got %0d want 1", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL zw_busy: got %b want 1", bok); end
        ref_apply(D0, 1'b0, 32'h1000, '0, '0);
        xact(D0, 1'b0, 32'h1000, '0, '0, lat, rd, err, bok);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zw_rd_lat: got %0d want 1", lat); end
        n_cmp++; if (rd !== ref_rd[D0]) begin n_bad++;
            $display("FAIL zw_wrap_data: got %h want %h", rd, ref_rd[D0]); end
    endtask

    task automatic test_busy_ignore();
        int          cyc[$];
        logic [31:0] val[$];
        logic [31:0] exp_a, exp_b;
        ref_apply(D2, 1'b0, 32'h10, '0, '0);
        exp_a = ref_rd[D2];
        ref_apply(D2, 1'b0, 32'h20, '0, '0);
        exp_b = ref_rd[D2];
        @(negedge clk);
        drive(D2, 1'b1, 1'b0, 32'h10, '0, '0);
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (bus2.ready) begin cyc.push_back(c); val.push_back(bus2.rdata); end
            if (c == 0) drive(D2, 1'b1, 1'b0, 32'h20, '0, '0);
            if (c == 5) drive(D2, 1'b0, 1'b0, '0, '0, '0);
        end
        n_cmp++; if (cyc.size() !== 2) begin n_bad++;
            $display("FAIL bi_count: got %0d ready pulses want 2", cyc.size()); end
        if (cyc.size() == 2) begin
            n_cmp++; if (cyc[0] !== 3 || cyc[1] !== 8) begin n_bad++;
                $display("FAIL bi_timing: got %0d,%0d want 3,8", cyc[0], cyc[1]); end
            n_cmp++; if (val[0] !== exp_a || val[1] !== exp_b) begin n_bad++;
                $display("FAIL bi_data: got %h,%h want %h,%h", val[0], val[1], exp_a, exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err, bok;
        logic saw_ready;
        ref_apply(D2, 1'b1, 32'h30, 32'h0, 4'hF);
        xact(D2, 1'b1, 32'h30, 32'h0, 4'hF, lat, rd, err, bok);
        @(negedge clk);
        drive(D2, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF);
        @(posedge clk);
        #1;
        drive(D2, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        saw_ready = 1'b0;
        n_cmp++; if (bus2.busy !== 1'b0 || bus2.rdata !== 32'd0) begin n_bad++;
            $display("FAIL rm_state: got busy %b rdata %h want 0/0", bus2.busy, bus2.rdata); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus2.ready) saw_ready = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus2.ready) saw_ready = 1'b1;
        end
        n_cmp++; if (saw_ready !== 1'b0) begin n_bad++;
            $display("FAIL rm_ready: got %b want 0", saw_ready); end
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        ref_apply(D2, 1'b0, 32'h30, '0, '0);
        xact(D2, 1'b0, 32'h30, '0, '0, lat, rd, err, bok);
        n_cmp++; if (rd !== ref_rd[D2]) begin n_bad++;
            $display("FAIL rm_aborted_write: got %h want %h", rd, ref_rd[D2]); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic err, bok;
        ref_apply(D2, 1'b1, 32'h31, 32'hCAFEF00D, 4'hF);
        xact(D2, 1'b1, 32'h31, 32'hCAFEF00D, 4'hF, lat, rd, err, bok);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mis_lat: got %0d want 3", lat); end
        n_cmp++; if (err !== ref_err(32'h31)) begin n_bad++;
            $display("FAIL mis_err: got %b want %b", err, ref_err(32'h31)); end
        ref_apply(D2, 1'b0, 32'h30, '0, '0);
        xact(D2, 1'b0, 32'h30, '0, '0, lat, rd, err, bok);
        n_cmp++; if (rd !== ref_rd[D2]) begin n_bad++;
            $display("FAIL mis_data: got %h want %h", rd, ref_rd[D2]); end
    endtask

    task automatic test_random();
        int          pool[6];
        int          lat, d, ix;
        logic [31:0] rd, a, wd;
        logic [3:0]  be;
        logic        w, err, bok, low_nz;
        for (int i = 0; i < 6; i++) pool[i] = int'($urandom_range(Depth - 1, 0));
        for (int i = 0; i < 52; i++) begin
            // First 12 iterations fill the pool words on both instances with full writes.
            if (i < 12) begin
                d = i % 2; ix = pool[i / 2]; w = 1'b1; be = 4'hF; low_nz = 1'b0;
            end else begin
                d = int'($urandom_range(1, 0)); ix = pool[$urandom_range(5, 0)];
                w = 1'($urandom_range(1, 0)); be = 4'($urandom());
                low_nz = ($urandom_range(3, 0) == 0);
            end
            a = ($urandom() & 32'hFFFFF000) | (32'(ix) << 2);
            if (low_nz) a = a | 32'($urandom_range(3, 1));
            wd = $urandom();
            ref_apply(d, w, a, wd, be);
            xact(d, w, a, wd, be, lat, rd, err, bok);
            n_cmp++; if (lat !== exp_lat(d)) begin n_bad++;
                $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, exp_lat(d)); end
            n_cmp++; if (rd !== ref_rd[d]) begin n_bad++;
                $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, ref_rd[d]); end
            n_cmp++; if (err !== ref_err(a)) begin n_bad++;
                $display("FAIL rnd%0d_err: got %b want %b", i, err, ref_err(a)); end
            n_cmp++; if (bok !== 1'b1) begin n_bad++;
                $display("FAIL rnd%0d_busy: got %b want 1", i, bok); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_zero_wait();
        test_busy_ignore();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
